uart_rx_cfg: RTL
================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Configurable data width, parity mode and stop-bit count. Adds an input synchroniser, 3-sample majority voting at each bit centre, and parity, framing and break error reporting. Sits between the board RX pin and byte consumers such as the command parser or FIFO, in the `clk` domain.

Parameters:
CLK_FREQ, 12_000_000, system clock frequency in Hz.
BAUDRATE, 9600, line rate. BIT = CLK_FREQ/BAUDRATE (integer divide). BIT >= 8 is required; elaborate-time error otherwise.
DATA_BITS, 8, data bits per frame, legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, legal values 1 or 2.
SYNC_STAGES, 2, synchroniser flops on rx, minimum 2.

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
rx  in  1  asynchronous serial input; idle high
rx_data  out  DATA_BITS  last received word, LSB = first bit on the wire
received  out  1  1-cycle pulse when a frame completes (not for breaks)
parity_error  out  1  qualifies received; 1 = parity mismatch
framing_error  out  1  qualifies received or break_detected; 1 = any stop bit sampled 0
break_detected  out  1  1-cycle pulse on a break condition

Behaviour:
- Reset, sampled on the clk edge with resetn = 0:
  - state = IDLE, counter = 0.
  - Synchroniser flops = 1.
  - rx_data = 0. All pulse and flag outputs = 0.
  - Reset mid-frame discards the frame with no pulse. Receive resumes on the first low seen after resetn = 1.
- Counter width is $clog2(BIT). HALF = BIT/2.
- Majority voting: each bit value is the 2-of-3 majority of synced rx at counts HALF-1, HALF and HALF+1 into the bit period. The decision is taken at HALF+1.
- States:
  - IDLE: stay while synced rx = 1. On synced rx = 0, go to START with counter cleared.
  - START: at the decision point, majority = 1 is a glitch → IDLE, no outputs. Majority = 0 → DATA.
  - DATA: shifts DATA_BITS bits in, LSB first. Next state is PARITY if PARITY != 0, else STOP.
  - PARITY: check = XOR(data bits, parity bit). Error if check = 0 with PARITY = 1, or check = 1 with PARITY = 2.
  - STOP: samples STOP_BITS stop bits. Any 0 sets framing_error.
- Bit timing: each subsequent bit's decision falls exactly BIT cycles after the previous one. There is no resync inside a frame.
- End of frame, one cycle after the last stop decision:
  - rx_data loads the shift register (rx_data is held between frames).
  - received = 1 with parity_error and framing_error valid in the same cycle.
  - All three clear the next cycle. State → IDLE.
- Break: all data bits, the parity bit (if present) and the first stop bit all sample 0.
  - Response: break_detected = 1 and framing_error = 1 for one cycle. received stays 0 and rx_data is unchanged.
  - State → BREAK_WAIT.
- BREAK_WAIT: holds until synced rx has been continuously 1 for BIT cycles, then → IDLE. Lows shorter than that restart the wait.
- Framing error without break: received still pulses. The next start is searched for immediately in IDLE; no extra half-bit skip.
- Flags are never sticky. A consumer must capture them on the received or break_detected cycle.
- Latency from the rx falling edge to the received pulse: SYNC_STAGES + (DATA_BITS + P + STOP_BITS + 0.5)·BIT + 2 cycles, where P = (PARITY != 0). Bench tolerance is ±2 cycles.

Test Plan:
Sim parameters: CLK_FREQ=160, BAUDRATE=10 (BIT=16). The bench drives rx with ideal frames unless stated.

1. 8N1, frame 0xA5 → exactly one received pulse; rx_data=8'hA5; parity_error = framing_error = break_detected = 0. Then back-to-back 0x00, 0xFF → two pulses with matching data.
2. DATA_BITS=7, PARITY=2, data 7'h55 with parity bit 0 → received, no error. Same frame with parity bit 1 → received=1 and parity_error=1. PARITY=1 with 7'h55 and parity bit 1 → no error.
3. STOP_BITS=2, frame 0x3C with the second stop bit 0 → received=1, framing_error=1, rx_data=8'h3C. The next valid frame 0x81 is received cleanly.
4. rx low for 5 cycles while IDLE (< HALF+1) → no pulses, state returns to IDLE. A following 0x42 frame decodes correctly.
5. rx held low for 12 bit periods, then high → one break_detected pulse with framing_error=1, received=0, rx_data unchanged. A frame starting 8 cycles after rx rises is ignored. A frame starting ≥16 cycles after rx rises is received.
6. A 1-cycle inverted spike at count HALF of data bit 3 in 0xF0 → rx_data=8'hF0. Separately, resetn pulsed low mid-frame → no pulse, and the next full frame 0x99 is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg_if.sv
// Line-side bundle of the configurable UART receiver: the rx pin plus the
// received word and the flags that qualify it.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 received;
    logic                 parity_error;
    logic                 framing_error;
    logic                 break_detected;

    // master drives the pin and consumes words; slave is the receiver itself
    modport master (
        output rx,
        input  rx_data, received, parity_error, framing_error, break_detected
    );

    modport slave (
        input  rx,
        output rx_data, received, parity_error, framing_error, break_detected
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: synchronised rx, 3-sample majority vote per bit,
// configurable data width, parity and stop bits, with parity/framing/break flags.
module uart_rx_cfg #(
    parameter int CLK_FREQ    = 12_000_000,
    parameter int BAUDRATE    = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         resetn,
    uart_rx_cfg_if.slave bus
);
    localparam int BIT  = CLK_FREQ / BAUDRATE;
    localparam int HALF = BIT / 2;
    localparam int CW   = $clog2(BIT);

    localparam logic [CW-1:0] CNT_PRE   = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(HALF);
    localparam logic [CW-1:0] CNT_DEC   = CW'(HALF + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BIT - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    if (BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || SYNC_STAGES < 2) begin : g_param_check
        $error("uart_rx_cfg: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK_WAIT
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic [1:0]             smp_q;
    logic [3:0]             data_idx_q;
    logic                   stop_idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;
    logic                   ones_q;
    logic                   stop_err_q;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   received_q;
    logic                   parity_err_q;
    logic                   framing_err_q;
    logic                   break_q;

    logic                   rx_s;
    logic                   vote;
    logic                   at_dec;
    logic [CW-1:0]          cnt_d;
    logic                   parity_err_d;
    logic                   framing_err_d;

    always_comb begin
        rx_s          = sync_q[SYNC_STAGES-1];
        vote          = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
        at_dec        = (cnt_q == CNT_DEC);
        cnt_d         = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        framing_err_d = stop_err_q | ~vote;
        // par_q ends up as XOR of data and parity bit; odd parity wants it set
        parity_err_d  = (PARITY == 1) ? ~par_q : (PARITY == 2) ? par_q : 1'b0;
    end

    // NOTE: the synchroniser resets to the idle level (1) so leaving reset
    // can never look like a start bit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            smp_q         <= '0;
            data_idx_q    <= '0;
            stop_idx_q    <= 1'b0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            ones_q        <= 1'b0;
            stop_err_q    <= 1'b0;
            rx_data_q     <= '0;
            received_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            break_q       <= 1'b0;
        end else begin
            // NOTE: pulses and flags default low each cycle; only the
            // end-of-frame and break branches raise them, so none can stick.
            received_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            break_q       <= 1'b0;

            if (cnt_q == CNT_PRE) smp_q[0] <= rx_s;
            if (cnt_q == CNT_MID) smp_q[1] <= rx_s;

            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) state_q <= S_START;
                end

                S_START: begin
                    cnt_q <= cnt_d;
                    if (at_dec) begin
                        if (vote) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q    <= S_DATA;
                            data_idx_q <= '0;
                            stop_idx_q <= 1'b0;
                            par_q      <= 1'b0;
                            ones_q     <= 1'b0;
                            stop_err_q <= 1'b0;
                        end
                    end
                end

                S_DATA: begin
                    cnt_q <= cnt_d;
                    if (at_dec) begin
                        shift_q    <= {vote, shift_q[DATA_BITS-1:1]};
                        par_q      <= par_q ^ vote;
                        ones_q     <= ones_q | vote;
                        data_idx_q <= data_idx_q + 4'd1;
                        if (data_idx_q == LAST_DATA) begin
                            state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end
                end

                S_PARITY: begin
                    cnt_q <= cnt_d;
                    if (at_dec) begin
                        par_q   <= par_q ^ vote;
                        ones_q  <= ones_q | vote;
                        state_q <= S_STOP;
                    end
                end

                S_STOP: begin
                    cnt_q <= cnt_d;
                    if (at_dec) begin
                        // a line stuck low through the first stop bit is a break, not a word
                        if (!stop_idx_q && !ones_q && !vote) begin
                            break_q       <= 1'b1;
                            framing_err_q <= 1'b1;
                            cnt_q         <= '0;
                            state_q       <= S_BREAK_WAIT;
                        end else if (stop_idx_q == LAST_STOP) begin
                            rx_data_q     <= shift_q;
                            received_q    <= 1'b1;
                            parity_err_q  <= parity_err_d;
                            framing_err_q <= framing_err_d;
                            state_q       <= S_IDLE;
                        end else begin
                            stop_err_q <= framing_err_d;
                            stop_idx_q <= 1'b1;
                        end
                    end
                end

                S_BREAK_WAIT: begin
                    if (!rx_s) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_data        = rx_data_q;
    assign bus.received       = received_q;
    assign bus.parity_error   = parity_err_q;
    assign bus.framing_error  = framing_err_q;
    assign bus.break_detected = break_q;
endmodule
